ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Upstream input stage for the game controller FSM.
- Receives PS/2 keyboard frames, tracks make/break and E0-extended codes, and drives level-held key outputs.
- The controller's move/place/jump/go inputs are driven directly from these outputs.
- A level stays high while the physical key is held, which matches the controller's wait-until-release states.

Parameters:
- TIMEOUT_CYC, 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock from the connector, asynchronous
- ps2_dat  in  1  raw PS/2 data from the connector, asynchronous
- move_up  out  1  high while Up arrow (E0 75) is held
- move_down  out  1  high while Down arrow (E0 72) is held
- move_left  out  1  high while Left arrow (E0 6B) is held
- move_right  out  1  high while Right arrow (E0 74) is held
- place  out  1  high while Space (29) is held
- jump  out  1  high while J (3B) is held
- go  out  1  high while Enter (5A) is held
- rx_code  out  8  last correctly received byte
- rx_valid  out  1  one-cycle pulse when rx_code updates
- frame_err  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset: all outputs 0; rx_code = 8'h00; receiver bit count = 0; decoder state = IDLE; timeout counter = 0.

Input synchronisation:
- ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
- A falling edge is synced ps2_clk going 1->0 on consecutive clk samples.

Receiver:
- One bit is sampled per falling edge, into an 11-bit frame: start (must be 0), 8 data bits LSB first, odd parity, stop (must be 1).
- On the 11th bit the frame is checked.
- Good frame: rx_code takes the data byte and rx_valid pulses on the next clk.
- Bad start, parity or stop: frame_err pulses instead, rx_code is unchanged, and the decoder is forced to IDLE.
- Timeout counter:
  - Clears on every falling edge.
  - Counts only while bit count is non-zero.
  - On reaching TIMEOUT_CYC: bit count returns to 0 and frame_err pulses.
  - Saturates; it never wraps.

Decoder FSM (advances only on rx_valid, using rx_code):
- States: IDLE, EXT (seen E0), BRK (seen F0), EXT_BRK (seen E0 F0).
- IDLE: E0 -> EXT; F0 -> BRK; any other code is a make of a base key -> IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT; other -> make of an extended key -> IDLE.
- BRK: E0 or F0 -> IDLE (resync, no action); other -> break of a base key -> IDLE.
- EXT_BRK: E0 or F0 -> IDLE; other -> break of an extended key -> IDLE.

Key outputs:
- Make sets the mapped output; break clears it.
- The output changes exactly one clk after the rx_valid pulse.
- Unmapped codes cause no output change, but the FSM still transitions.
- Base code 75 (keypad 8) is distinct from E0 75 and must not drive move_up.
- Typematic repeats (repeated makes) leave an already-high output high.
- Outputs are independent; several may be high at once.

Reset mid-frame: every register returns to its reset value immediately, with no pulse emitted.

Optional Feature:
- Macro: WASD_ALIAS_EN.
- Defined: base codes 1D (W), 1B (S), 1C (A), 23 (D) are tracked in their own held bits. move_up/down/left/right = arrow bit OR WASD bit, so releasing one source while the other is held keeps the output high.
- Undefined: these codes are unmapped and ignored.

Test Plan:
- Send frames E0, 75 (all valid) -> move_up rises 1 clk after the second rx_valid. Then send E0, F0, 75 -> move_up falls 1 clk after the third rx_valid; no other output toggles.
- Send 29, then 29 repeated 3 times, then F0 29 -> place high from the first make until 1 clk after the break; rx_valid pulses 6 times in total.
- Frame for 5A with the parity bit inverted -> frame_err pulses once, rx_code is unchanged, go stays 0. A following valid 5A sets go.
- Send 4 bits of a frame, then hold ps2_clk high for TIMEOUT_CYC+10 clk -> frame_err pulses once. A following full valid frame 3B sets jump.
- Hold E0 6B (left) and 29 (place), then assert reset_n=0 mid-frame -> all outputs 0 immediately. After release, a valid 75 frame leaves move_up at 0.
- With WASD_ALIAS_EN: send 1C, then E0 6B, then F0 1C -> move_left stays 1. A further E0 F0 6B -> move_left drops to 0.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: PS/2 line inputs plus decoded key levels and receive status.
// Rev 1.0
`default_nettype none

interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       move_up;
  logic       move_down;
  logic       move_left;
  logic       move_right;
  logic       place;
  logic       jump;
  logic       go;
  logic [7:0] rx_code;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  move_up, move_down, move_left, move_right, place, jump, go,
    input  rx_code, rx_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output move_up, move_down, move_left, move_right, place, jump, go,
    output rx_code, rx_valid, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver with make/break/E0 decoding into held key levels.
// Optional macro WASD_ALIAS_EN folds W/S/A/D into the move outputs. Rev 1.0
`default_nettype none

module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  ps2_key_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Synchronisers idle high so release from reset never looks like a falling edge.
  logic [2:0] clk_sync;
  logic [1:0] dat_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], bus.ps2_clk};
      dat_sync <= {dat_sync[0], bus.ps2_dat};
    end
  end

  logic        fall;
  logic [10:0] frame;
  logic        frame_ok;
  logic [9:0]  shift;
  logic [3:0]  bit_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [7:0]  rx_code;
  logic        rx_valid;
  logic        frame_err;
  logic        bad_frame;

  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign frame    = {dat_sync[1], shift};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      rx_code   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      bad_frame <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      bad_frame <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        shift  <= {dat_sync[1], shift[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_code  <= frame[8:1];
            rx_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            bad_frame <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          to_cnt    <= TO_MAX;
          bit_cnt   <= '0;
          frame_err <= 1'b1;
        end else if (to_cnt != TO_MAX) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  state_t state;
  state_t state_nxt;
  logic   do_make;
  logic   do_break;
  logic   is_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (bad_frame) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_break  = 1'b0;
    is_ext    = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_code == 8'hE0)      state_nxt = EXT;
          else if (rx_code == 8'hF0) state_nxt = BRK;
          else begin
            state_nxt = IDLE;
            do_make   = 1'b1;
          end
        end
        EXT: begin
          if (rx_code == 8'hF0)      state_nxt = EXT_BRK;
          else if (rx_code == 8'hE0) state_nxt = EXT;
          else begin
            state_nxt = IDLE;
            do_make   = 1'b1;
            is_ext    = 1'b1;
          end
        end
        BRK: begin
          state_nxt = IDLE;
          if (rx_code != 8'hE0 && rx_code != 8'hF0) do_break = 1'b1;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          if (rx_code != 8'hE0 && rx_code != 8'hF0) begin
            do_break = 1'b1;
            is_ext   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  logic up_arrow, down_arrow, left_arrow, right_arrow;
  logic place_key, jump_key, go_key;
`ifdef WASD_ALIAS_EN
  logic w_key, s_key, a_key, d_key;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_arrow    <= 1'b0;
      down_arrow  <= 1'b0;
      left_arrow  <= 1'b0;
      right_arrow <= 1'b0;
      place_key   <= 1'b0;
      jump_key    <= 1'b0;
      go_key      <= 1'b0;
`ifdef WASD_ALIAS_EN
      w_key       <= 1'b0;
      s_key       <= 1'b0;
      a_key       <= 1'b0;
      d_key       <= 1'b0;
`endif
    end else if (do_make || do_break) begin
      if (is_ext) begin
        case (rx_code)
          8'h75:   up_arrow    <= do_make;
          8'h72:   down_arrow  <= do_make;
          8'h6B:   left_arrow  <= do_make;
          8'h74:   right_arrow <= do_make;
          default: ;
        endcase
      end else begin
        // Base 75 is keypad 8 and deliberately falls through to default.
        case (rx_code)
          8'h29:   place_key <= do_make;
          8'h3B:   jump_key  <= do_make;
          8'h5A:   go_key    <= do_make;
`ifdef WASD_ALIAS_EN
          8'h1D:   w_key     <= do_make;
          8'h1B:   s_key     <= do_make;
          8'h1C:   a_key     <= do_make;
          8'h23:   d_key     <= do_make;
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef WASD_ALIAS_EN
  assign bus.move_up    = up_arrow    | w_key;
  assign bus.move_down  = down_arrow  | s_key;
  assign bus.move_left  = left_arrow  | a_key;
  assign bus.move_right = right_arrow | d_key;
`else
  assign bus.move_up    = up_arrow;
  assign bus.move_down  = down_arrow;
  assign bus.move_left  = left_arrow;
  assign bus.move_right = right_arrow;
`endif
  assign bus.place      = place_key;
  assign bus.jump       = jump_key;
  assign bus.go         = go_key;
  assign bus.rx_code    = rx_code;
  assign bus.rx_valid   = rx_valid;
  assign bus.frame_err  = frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames with hand-computed key levels.
`default_nettype none

module tb_ps2_key_decoder;

  localparam int TIMEOUT_CYC = 50000;

  localparam logic [6:0] K_UP    = 7'b1000000;
  localparam logic [6:0] K_DOWN  = 7'b0100000;
  localparam logic [6:0] K_LEFT  = 7'b0010000;
  localparam logic [6:0] K_RIGHT = 7'b0001000;
  localparam logic [6:0] K_PLACE = 7'b0000100;
  localparam logic [6:0] K_JUMP  = 7'b0000010;
  localparam logic [6:0] K_GO    = 7'b0000001;

  logic clk;
  logic reset_n;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] keys;
  assign keys = {bus.move_up, bus.move_down, bus.move_left, bus.move_right,
                 bus.place, bus.jump, bus.go};

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int cyc = 0;
  int last_err_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_valid) n_valid <= n_valid + 1;
    if (bus.frame_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
  end

  logic       got_valid;
  logic       got_err;
  logic [6:0] keys_pre;
  logic [6:0] keys_post;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of frame f; on a full frame, snapshots keys on the
  // status pulse and one clk later.
  task automatic send_raw(input logic [10:0] f, input int nbits);
    got_valid = 1'b0;
    got_err   = 1'b0;
    keys_pre  = 'x;
    keys_post = 'x;
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_dat = f[i];
      repeat (5) @(posedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (bus.rx_valid || bus.frame_err) begin
            got_valid = bus.rx_valid;
            got_err   = bus.frame_err;
            keys_pre  = keys;
            @(negedge clk);
            keys_post = keys;
            break;
          end
        end
        @(posedge clk);
      end else begin
        repeat (10) @(posedge clk);
      end
      bus.ps2_clk = 1'b1;
      repeat (5) @(posedge clk);
    end
    bus.ps2_dat = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_raw(f, 11);
  endtask

  task automatic send_ok(input string tag, input logic [7:0] b, input logic [6:0] exp_keys);
    send(b, 1'b0);
    check({tag, "_valid"}, {31'd0, got_valid}, 32'd1);
    check({tag, "_keys"}, {25'd0, keys_post}, {25'd0, exp_keys});
  endtask

  int v0;
  int e0;
  int dt;

  initial begin
    reset_n     = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_keys", {25'd0, keys}, 32'd0);
    check("rst_code", {24'd0, bus.rx_code}, 32'd0);
    check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_err", {31'd0, bus.frame_err}, 32'd0);
    @(posedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Up arrow make then break, with exact one-clk latency
    send_ok("e0", 8'hE0, 7'd0);
    check("e0_code", {24'd0, bus.rx_code}, 32'hE0);
    send(8'h75, 1'b0);
    check("up_valid", {31'd0, got_valid}, 32'd1);
    check("up_pre", {25'd0, keys_pre}, 32'd0);
    check("up_post", {25'd0, keys_post}, {25'd0, K_UP});
    check("up_code", {24'd0, bus.rx_code}, 32'h75);
    send_ok("upb_e0", 8'hE0, K_UP);
    send_ok("upb_f0", 8'hF0, K_UP);
    send(8'h75, 1'b0);
    check("upb_pre", {25'd0, keys_pre}, {25'd0, K_UP});
    check("upb_post", {25'd0, keys_post}, 32'd0);

    // Space with typematic repeats
    v0 = n_valid;
    send_ok("sp1", 8'h29, K_PLACE);
    for (int r = 0; r < 3; r++) send_ok("sp_rep", 8'h29, K_PLACE);
    send_ok("sp_f0", 8'hF0, K_PLACE);
    send(8'h29, 1'b0);
    check("spb_pre", {25'd0, keys_pre}, {25'd0, K_PLACE});
    check("spb_post", {25'd0, keys_post}, 32'd0);
    check("sp_nvalid", n_valid - v0, 32'd6);

    // Bad parity is dropped, then a good Enter
    e0 = n_err;
    send(8'h5A, 1'b1);
    check("par_err", {31'd0, got_err}, 32'd1);
    check("par_valid", {31'd0, got_valid}, 32'd0);
    check("par_code", {24'd0, bus.rx_code}, 32'h29);
    check("par_keys", {25'd0, keys_post}, 32'd0);
    check("par_nerr", n_err - e0, 32'd1);
    send_ok("go", 8'h5A, K_GO);

    // A bad frame after E0 returns the decoder to IDLE, so 75 is keypad 8
    send_ok("fi_e0", 8'hE0, K_GO);
    send(8'h11, 1'b1);
    check("fi_err", {31'd0, got_err}, 32'd1);
    send_ok("fi_75", 8'h75, K_GO);

    // F0 then E0 resyncs to IDLE; 72 is then an unmapped base make
    send_ok("rs_f0", 8'hF0, K_GO);
    send_ok("rs_e0", 8'hE0, K_GO);
    send_ok("rs_72", 8'h72, K_GO);

    // Partial frame abandoned by the timeout
    e0 = n_err;
    send_raw({1'b1, 1'b1, 8'h3B, 1'b0}, 4);
    v0 = cyc;
    repeat (TIMEOUT_CYC + 10) @(posedge clk);
    check("to_nerr", n_err - e0, 32'd1);
    dt = last_err_cyc - v0;
    check("to_time", {31'd0, (dt >= TIMEOUT_CYC - 40) && (dt <= TIMEOUT_CYC)}, 32'd1);
    check("to_keys", {25'd0, keys}, {25'd0, K_GO});
    send_ok("jump", 8'h3B, K_GO | K_JUMP);

`ifdef WASD_ALIAS_EN
    send_ok("a_make", 8'h1C, K_GO | K_JUMP | K_LEFT);
    send_ok("l_e0", 8'hE0, K_GO | K_JUMP | K_LEFT);
    send_ok("l_make", 8'h6B, K_GO | K_JUMP | K_LEFT);
    send_ok("a_f0", 8'hF0, K_GO | K_JUMP | K_LEFT);
    send_ok("a_brk", 8'h1C, K_GO | K_JUMP | K_LEFT);
    send_ok("l_e0b", 8'hE0, K_GO | K_JUMP | K_LEFT);
    send_ok("l_f0b", 8'hF0, K_GO | K_JUMP | K_LEFT);
    send_ok("l_brk", 8'h6B, K_GO | K_JUMP);
    send_ok("w_make", 8'h1D, K_GO | K_JUMP | K_UP);
    send_ok("w_f0", 8'hF0, K_GO | K_JUMP | K_UP);
    send_ok("w_brk", 8'h1D, K_GO | K_JUMP);
`else
    send_ok("a_unmap", 8'h1C, K_GO | K_JUMP);
    send_ok("w_unmap", 8'h1D, K_GO | K_JUMP);
    send_ok("d_unmap", 8'h23, K_GO | K_JUMP);
`endif

    // Reset mid-frame while several keys are held
    send_ok("rl_e0", 8'hE0, K_GO | K_JUMP);
    send_ok("rl_6b", 8'h6B, K_GO | K_JUMP | K_LEFT);
    send_ok("rl_29", 8'h29, K_GO | K_JUMP | K_LEFT | K_PLACE);
    send_ok("rl_74e", 8'hE0, K_GO | K_JUMP | K_LEFT | K_PLACE);
    send_ok("rl_74", 8'h74, K_GO | K_JUMP | K_LEFT | K_PLACE | K_RIGHT);
    e0 = n_err;
    send_raw({1'b1, 1'b0, 8'h5A, 1'b0}, 4);
    reset_n = 1'b0;
    #1;
    check("mid_keys", {25'd0, keys}, 32'd0);
    check("mid_code", {24'd0, bus.rx_code}, 32'd0);
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    check("mid_nerr", n_err - e0, 32'd0);
    send_ok("kp8", 8'h75, 7'd0);
    check("kp8_code", {24'd0, bus.rx_code}, 32'h75);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
